// File: rtl/axis_tx_pkg.sv
// Shared types and default sizing for the AXI-Stream transmitter slice.
package axis_tx_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  typedef logic [DEF_LEN_WIDTH-1:0] len_t;

endpackage

// File: rtl/axis_tx_fifo.sv
// Prefetch FIFO: head word is visible the cycle after it is written.
// A push while full is taken only if a pop frees a slot on the same edge.
module axis_tx_fifo
  import axis_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axis_master_tx.sv
// AXI-Stream master: streams a programmed number of FIFO words, flags the
// last beat with tlast and pulses finish_out the cycle after it completes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start_in with a non-zero length; FIFO may prefetch
// ST_SEND | presenting FIFO head while it holds data; counting handshakes
module axis_master_tx
  import axis_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic                  wr_valid_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  output logic                  wr_ready_out,
  input  logic                  tready_in,
  output logic                  tvalid_out,
  output logic [DATA_WIDTH-1:0] tdata_out,
  output logic                  tlast_out,
  output logic                  busy_out,
  output logic                  finish_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  tx_state_t             state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  finish_q, finish_d;

  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  sending, handshake, last_beat;

  axis_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push    (wr_valid_in),
    .wr_data (wr_data_in),
    .pop     (handshake),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  // tvalid comes only from registered state and FIFO occupancy, never tready.
  assign sending      = (state_q == ST_SEND);
  assign tvalid_out   = sending && !fifo_empty;
  assign last_beat    = (beat_cnt_q == len_q - LEN_WIDTH'(1));
  assign tlast_out    = tvalid_out && last_beat;
  assign handshake    = tvalid_out && tready_in;
  assign tdata_out    = tvalid_out ? fifo_head : '0;
  assign busy_out     = sending;
  assign finish_out   = finish_q;
  assign wr_ready_out = !fifo_full;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    finish_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in && (len_in != '0)) begin
          len_d      = len_in;
          beat_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (last_beat) begin
            state_d  = ST_IDLE;
            finish_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      finish_q   <= finish_d;
    end
  end

  a_fifo_count_bound : assert property (@(posedge aclk) disable iff (areset)
    fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_axis_master_tx.sv
// Scoreboard bench for axis_master_tx: expected beats are queued as words
// are pushed and popped by a monitor on every observed handshake.
module tb_axis_master_tx;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int FD = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start_in = 1'b0;
  logic [LW-1:0] len_in = '0;
  logic          wr_valid_in = 1'b0;
  logic [DW-1:0] wr_data_in = '0;
  logic          tready_in = 1'b0;
  logic          wr_ready_out, tvalid_out, tlast_out, busy_out, finish_out;
  logic [DW-1:0] tdata_out;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];

  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic          prev_reset = 1'b1;
  logic [DW-1:0] prev_data = '0;

  always #5 aclk = ~aclk;

  axis_master_tx #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .LEN_WIDTH  (LW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .start_in     (start_in),
    .len_in       (len_in),
    .wr_valid_in  (wr_valid_in),
    .wr_data_in   (wr_data_in),
    .wr_ready_out (wr_ready_out),
    .tready_in    (tready_in),
    .tvalid_out   (tvalid_out),
    .tdata_out    (tdata_out),
    .tlast_out    (tlast_out),
    .busy_out     (busy_out),
    .finish_out   (finish_out)
  );

  // Monitor: beat ordering/tlast against the scoreboard, and hold-stability.
  always @(negedge aclk) begin
    beat_t e;
    if (!areset) begin
      if (prev_valid && !prev_ready && !prev_reset) begin
        total++;
        if (tvalid_out !== 1'b1 || tdata_out !== prev_data || tlast_out !== prev_last) begin
          bad++;
          $display("FAIL hold_stable: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   tvalid_out, tdata_out, tlast_out, prev_data, prev_last);
        end
      end
      if (tvalid_out === 1'b1 && tready_in === 1'b1) begin
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got d=%h l=%b, want no beat", tdata_out, tlast_out);
        end else begin
          e = exp_q.pop_front();
          if (tdata_out !== e.data || tlast_out !== e.last) begin
            bad++;
            $display("FAIL beat: got d=%h l=%b, want d=%h l=%b",
                     tdata_out, tlast_out, e.data, e.last);
          end
        end
      end
    end
    prev_valid = tvalid_out;
    prev_ready = tready_in;
    prev_data  = tdata_out;
    prev_last  = tlast_out;
    prev_reset = areset;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push_word(input logic [DW-1:0] d);
    wr_valid_in = 1'b1;
    wr_data_in  = d;
    @(posedge aclk); #1;
    wr_valid_in = 1'b0;
  endtask

  task automatic start_pkt(input logic [LW-1:0] l);
    start_in = 1'b1;
    len_in   = l;
    @(posedge aclk); #1;
    start_in = 1'b0;
  endtask

  // Returns the index of the first negedge with finish_out high, or -1.
  task automatic wait_finish(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge aclk);
      if (finish_out === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(posedge aclk); #1;
    @(negedge aclk);
    total++;
    if ({tvalid_out, tlast_out, busy_out, finish_out, wr_ready_out} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_ctrl: got v/l/b/f/r=%b%b%b%b%b, want 00001",
               tvalid_out, tlast_out, busy_out, finish_out, wr_ready_out);
    end
    total++;
    if (tdata_out !== '0) begin
      bad++;
      $display("FAIL reset_tdata: got %h, want 0", tdata_out);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    tready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({DW'(32'hA0 + i), (i == 3)});
      push_word(DW'(32'hA0 + i));
    end
    start_pkt(8'd4);
    wait_finish(20, n);
    total++;
    if (n !== 5) begin
      bad++;
      $display("FAIL basic_finish_cycle: got %0d, want 5", n);
    end
    total++;
    if (busy_out !== 1'b0 || tvalid_out !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_at_finish: got busy=%b v=%b, want 0 0", busy_out, tvalid_out);
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    total++;
    if (finish_out !== 1'b0) begin
      bad++;
      $display("FAIL basic_finish_pulse: got %b, want 0", finish_out);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL basic_drained: got %0d left, want 0", exp_q.size());
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] words [3];
    int h0;
    logic done;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    tready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({words[i], (i == 2)});
      push_word(words[i]);
    end
    h0 = hs_cnt;
    done = 1'b0;
    start_pkt(8'd3);
    for (int k = 0; k < 30; k++) begin
      tready_in = (k % 3 == 0);
      @(negedge aclk);
      if (finish_out === 1'b1) begin
        done = 1'b1;
        break;
      end
      @(posedge aclk); #1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL bp_finish: got no finish, want finish within 30 cycles");
    end
    total++;
    if (hs_cnt - h0 != 3) begin
      bad++;
      $display("FAIL bp_handshakes: got %0d, want 3", hs_cnt - h0);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_starvation;
    int n;
    tready_in = 1'b1;
    start_pkt(8'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      total++;
      if (tvalid_out !== 1'b0 || busy_out !== 1'b1) begin
        bad++;
        $display("FAIL starve_wait: got v=%b busy=%b, want v=0 busy=1", tvalid_out, busy_out);
      end
      @(posedge aclk); #1;
    end
    exp_q.push_back({DW'(32'h55), 1'b0});
    push_word(32'h55);
    @(negedge aclk);
    total++;
    if (tvalid_out !== 1'b1 || tdata_out !== 32'h55) begin
      bad++;
      $display("FAIL starve_rise: got v=%b d=%h, want v=1 d=00000055", tvalid_out, tdata_out);
    end
    @(posedge aclk); #1;
    exp_q.push_back({DW'(32'h66), 1'b1});
    push_word(32'h66);
    wait_finish(10, n);
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL starve_finish: got %0d, want 2", n);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_fifo_full;
    int n;
    tready_in = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(32'hB0 + i));
    @(negedge aclk);
    total++;
    if (wr_ready_out !== 1'b0) begin
      bad++;
      $display("FAIL full_ready: got %b, want 0", wr_ready_out);
    end
    @(posedge aclk); #1;
    push_word(32'hB4);
    exp_q.push_back({DW'(32'hB0), 1'b0});
    exp_q.push_back({DW'(32'hB1), 1'b1});
    start_pkt(8'd2);
    @(negedge aclk);
    total++;
    if (tvalid_out !== 1'b1 || tdata_out !== 32'hB0 || tlast_out !== 1'b0) begin
      bad++;
      $display("FAIL full_head: got v=%b d=%h l=%b, want v=1 d=000000b0 l=0",
               tvalid_out, tdata_out, tlast_out);
    end
    @(posedge aclk); #1;
    tready_in   = 1'b1;
    wr_valid_in = 1'b1;
    wr_data_in  = 32'hB5;
    @(posedge aclk); #1;
    wr_valid_in = 1'b0;
    @(negedge aclk);
    total++;
    if (wr_ready_out !== 1'b0 || tdata_out !== 32'hB1 || tlast_out !== 1'b1) begin
      bad++;
      $display("FAIL full_push_pop: got r=%b d=%h l=%b, want r=0 d=000000b1 l=1",
               wr_ready_out, tdata_out, tlast_out);
    end
    @(posedge aclk); #1;
    wait_finish(10, n);
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL full_finish1: got %0d, want 1", n);
    end
    @(posedge aclk); #1;
    exp_q.push_back({DW'(32'hB2), 1'b0});
    exp_q.push_back({DW'(32'hB3), 1'b0});
    exp_q.push_back({DW'(32'hB5), 1'b1});
    start_pkt(8'd3);
    wait_finish(10, n);
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL full_finish2: got %0d, want 4", n);
    end
    total++;
    if (wr_ready_out !== 1'b1 || tvalid_out !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL full_drained: got r=%b v=%b left=%0d, want r=1 v=0 left=0",
               wr_ready_out, tvalid_out, exp_q.size());
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_boundaries;
    int n;
    logic seen;
    tready_in = 1'b1;
    start_pkt(8'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      if (busy_out !== 1'b0 || finish_out !== 1'b0) seen = 1'b1;
      @(posedge aclk); #1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL len0_ignored: got busy/finish activity, want none");
    end
    start_pkt(8'd1);
    @(negedge aclk);
    total++;
    if (busy_out !== 1'b1) begin
      bad++;
      $display("FAIL len1_busy: got %b, want 1", busy_out);
    end
    @(posedge aclk); #1;
    start_pkt(8'd3);
    exp_q.push_back({DW'(32'hC0), 1'b1});
    push_word(32'hC0);
    wait_finish(10, n);
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL len1_finish: got %0d, want 2", n);
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    total++;
    if (busy_out !== 1'b0) begin
      bad++;
      $display("FAIL start_while_busy: got busy=%b, want 0", busy_out);
    end
    @(posedge aclk); #1;
    tready_in = 1'b0;
    exp_q.push_back({DW'(32'hD0), 1'b1});
    exp_q.push_back({DW'(32'hD1), 1'b1});
    push_word(32'hD0);
    push_word(32'hD1);
    tready_in = 1'b1;
    start_pkt(8'd1);
    wait_finish(10, n);
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL b2b_finish1: got %0d, want 2", n);
    end
    start_in = 1'b1;
    len_in   = 8'd1;
    @(posedge aclk); #1;
    start_in = 1'b0;
    @(negedge aclk);
    total++;
    if (busy_out !== 1'b1 || tvalid_out !== 1'b1 || tdata_out !== 32'hD1 || tlast_out !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart: got b=%b v=%b d=%h l=%b, want b=1 v=1 d=000000d1 l=1",
               busy_out, tvalid_out, tdata_out, tlast_out);
    end
    wait_finish(10, n);
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL b2b_finish2: got %0d, want 1", n);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    logic seen;
    tready_in = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(32'hE0 + i));
    exp_q.push_back({DW'(32'hE0), 1'b0});
    exp_q.push_back({DW'(32'hE1), 1'b0});
    tready_in = 1'b1;
    start_pkt(8'd4);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset    = 1'b1;
    tready_in = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    total++;
    if ({tvalid_out, busy_out, finish_out, wr_ready_out} !== 4'b0001) begin
      bad++;
      $display("FAIL midreset_state: got v/b/f/r=%b%b%b%b, want 0001",
               tvalid_out, busy_out, finish_out, wr_ready_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      if (finish_out !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midreset_nofinish: got finish pulse, want none");
    end
    @(posedge aclk); #1;
    tready_in = 1'b1;
    exp_q.push_back({DW'(32'hF0), 1'b1});
    push_word(32'hF0);
    start_pkt(8'd1);
    wait_finish(10, n);
    total++;
    if (n !== 2 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL midreset_recover: got finish=%0d left=%0d, want finish=2 left=0",
               n, exp_q.size());
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_fifo_full();
    test_boundaries();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
